// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA operand load path.
//   - Operand-select codes driven on loading_state toward the register bank.
//   - Load sequencer state encoding.
//   - Default byte stride between consecutive 1024-bit operands.
package rsa_pkg;

  localparam int OPERAND_BYTES = 128;

  localparam logic [31:0] LOAD_NONE = 32'h0000_0000;
  localparam logic [31:0] LOAD_N    = 32'h0000_0009;
  localparam logic [31:0] LOAD_E    = 32'h0000_000A;
  localparam logic [31:0] LOAD_RN   = 32'h0000_000B;
  localparam logic [31:0] LOAD_R2N  = 32'h0000_000C;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } load_state_t;

endpackage

// File: rtl/operand_load_sequencer.sv
// operand_load_sequencer
// Loads up to four 1024-bit operands (N, e, R_N, R2_N) through the DMA
// receive channel, one DMA read per operand enabled in operand_mask, while
// presenting the operand-select code on loading_state.
//
// Optional feature: define LOAD_TIMEOUT_EN to add a per-transfer watchdog
// (TIMEOUT_CYCLES parameter and sticky timeout output).
//
// Ports:
//   clk, resetn             clock, async active-low reset
//   start                   one-cycle command, accepted only in IDLE
//   base_addr[31:0]         byte address of N; operand k at base + k*OPERAND_BYTES
//   operand_mask[3:0]       bit k enables operand k
//   loading_state[31:0]     operand-select code, 0 when not loading
//   dma_rx_address[31:0]    read address of the current transfer
//   dma_rx_start            one-cycle DMA request
//   dma_done/idle/error     DMA status
//   busy, done, error       status to the control FSM (error is sticky)
//   timeout                 sticky watchdog flag (LOAD_TIMEOUT_EN only)
//
// state | meaning
// IDLE  | waiting for start
// SEL   | next operand chosen (code/address already presented)
// REQ   | waiting for dma_idle, then pulse dma_rx_start
// WAIT  | transfer in flight, waiting for dma_done
// DONE  | all enabled operands loaded, pulse done
// ERROR | DMA error or watchdog expiry, flag error
module operand_load_sequencer #(
  parameter int OPERAND_BYTES = rsa_pkg::OPERAND_BYTES
`ifdef LOAD_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [3:0]  operand_mask,
  output logic [31:0] loading_state,
  output logic [31:0] dma_rx_address,
  output logic        dma_rx_start,
  input  logic        dma_done,
  input  logic        dma_idle,
  input  logic        dma_error,
  output logic        busy,
  output logic        done,
  output logic        error
`ifdef LOAD_TIMEOUT_EN
  , output logic      timeout
`endif
);

  import rsa_pkg::*;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [2:0] find_next(input logic [3:0] mask, input logic [2:0] from);
    logic [2:0] hit;
    hit = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if ((3'(i) >= from) && mask[i]) hit = {1'b1, 2'(i)};
    end
    return hit;
  endfunction

  function automatic logic [31:0] code_of(input logic [1:0] idx);
    logic [31:0] code;
    case (idx)
      2'd0:    code = LOAD_N;
      2'd1:    code = LOAD_E;
      2'd2:    code = LOAD_RN;
      default: code = LOAD_R2N;
    endcase
    return code;
  endfunction

  load_state_t r_state;
  logic [3:0]  r_mask;
  logic [31:0] r_base;
  logic [1:0]  r_k;
  logic        r_hit;
  logic [31:0] r_loading_state;
  logic [31:0] r_dma_rx_address;
  logic        r_dma_rx_start;
  logic        r_busy;
  logic        r_done;
  logic        r_error;
`ifdef LOAD_TIMEOUT_EN
  logic        r_timeout;
  logic [31:0] r_cnt;
`endif

  // The next operand is resolved on the way into SEL (from IDLE or WAIT),
  // so code and address are already stable while SEL is occupied.
  logic [3:0]  w_scan_mask;
  logic [31:0] w_scan_base;
  logic [2:0]  w_scan_from;
  logic [2:0]  w_hit;
  logic        w_found;
  logic [1:0]  w_idx;
  logic [31:0] w_addr;
  logic [31:0] w_code;

  always_comb begin
    w_scan_mask = r_mask;
    w_scan_base = r_base;
    w_scan_from = {1'b0, r_k} + 3'd1;
    if (r_state == ST_IDLE) begin
      w_scan_mask = operand_mask;
      w_scan_base = base_addr;
      w_scan_from = 3'd0;
    end
    w_hit   = find_next(w_scan_mask, w_scan_from);
    w_found = w_hit[2];
    w_idx   = w_hit[1:0];
    w_addr  = w_scan_base + (32'(w_idx) * 32'(OPERAND_BYTES));
    w_code  = w_found ? code_of(w_idx) : LOAD_NONE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state          <= ST_IDLE;
      r_mask           <= 4'b0000;
      r_base           <= 32'h0;
      r_k              <= 2'd0;
      r_hit            <= 1'b0;
      r_loading_state  <= LOAD_NONE;
      r_dma_rx_address <= 32'h0;
      r_dma_rx_start   <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_error          <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
      r_timeout        <= 1'b0;
      r_cnt            <= 32'h0;
`endif
    end else begin
      r_dma_rx_start <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mask          <= operand_mask;
            r_base          <= base_addr;
            r_error         <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
            r_timeout       <= 1'b0;
`endif
            r_busy          <= 1'b1;
            r_k             <= w_idx;
            r_hit           <= w_found;
            r_loading_state <= w_code;
            if (w_found) r_dma_rx_address <= w_addr;
            r_state         <= ST_SEL;
          end
        end
        ST_SEL: begin
          if (r_hit) begin
            r_state <= ST_REQ;
          end else begin
            r_busy          <= 1'b0;
            r_loading_state <= LOAD_NONE;
            r_state         <= ST_DONE;
          end
        end
        ST_REQ: begin
          if (dma_error) begin
            r_error         <= 1'b1;
            r_busy          <= 1'b0;
            r_loading_state <= LOAD_NONE;
            r_state         <= ST_ERROR;
          end else if (dma_idle) begin
            r_dma_rx_start <= 1'b1;
`ifdef LOAD_TIMEOUT_EN
            r_cnt          <= 32'h0;
`endif
            r_state        <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Error has priority over a coincident dma_done; k is not advanced.
          if (dma_error) begin
            r_error         <= 1'b1;
            r_busy          <= 1'b0;
            r_loading_state <= LOAD_NONE;
            r_state         <= ST_ERROR;
          end else if (dma_done) begin
            if (r_k == 2'd3) begin
              r_busy          <= 1'b0;
              r_loading_state <= LOAD_NONE;
              r_state         <= ST_DONE;
            end else begin
              r_k             <= w_idx;
              r_hit           <= w_found;
              r_loading_state <= w_code;
              if (w_found) r_dma_rx_address <= w_addr;
              r_state         <= ST_SEL;
            end
          end
`ifdef LOAD_TIMEOUT_EN
          else if (r_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
            r_timeout       <= 1'b1;
            r_error         <= 1'b1;
            r_busy          <= 1'b0;
            r_loading_state <= LOAD_NONE;
            r_state         <= ST_ERROR;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
`endif
        end
        ST_DONE: begin
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        ST_ERROR: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign loading_state  = r_loading_state;
  assign dma_rx_address = r_dma_rx_address;
  assign dma_rx_start   = r_dma_rx_start;
  assign busy           = r_busy;
  assign done           = r_done;
  assign error          = r_error;
`ifdef LOAD_TIMEOUT_EN
  assign timeout        = r_timeout;
`endif

endmodule

// File: tb/tb_operand_load_sequencer.sv
module tb_operand_load_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'h0;
  logic [3:0]  operand_mask = 4'h0;
  logic [31:0] loading_state;
  logic [31:0] dma_rx_address;
  logic        dma_rx_start;
  logic        dma_done = 1'b0;
  logic        dma_idle = 1'b1;
  logic        dma_error = 1'b0;
  logic        busy, done, error;
`ifdef LOAD_TIMEOUT_EN
  logic        timeout;
`else
  logic        timeout;
  assign timeout = 1'b0;
`endif

  operand_load_sequencer #(
    .OPERAND_BYTES(128)
`ifdef LOAD_TIMEOUT_EN
    , .TIMEOUT_CYCLES(20)
`endif
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
    .operand_mask(operand_mask), .loading_state(loading_state),
    .dma_rx_address(dma_rx_address), .dma_rx_start(dma_rx_start),
    .dma_done(dma_done), .dma_idle(dma_idle), .dma_error(dma_error),
    .busy(busy), .done(done), .error(error)
`ifdef LOAD_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [31:0] addr;
    logic [31:0] code;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_starts = 0;
  bit   auto_dma = 1'b1;
  int   err_on = 0;
  int   xfer_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_x(input logic [31:0] addr, input logic [31:0] code);
    exp_t e;
    e.is_done = 1'b0; e.addr = addr; e.code = code;
    q.push_back(e);
  endtask

  task automatic push_done();
    exp_t e;
    e.is_done = 1'b1; e.addr = 32'h0; e.code = 32'h0;
    q.push_back(e);
  endtask

  // Monitor: every DMA request and every done pulse must match the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (dma_rx_start) begin
          n_starts++;
          if (q.size() == 0) chk("unexpected_dma_rx_start", 32'd1, 32'd0);
          else begin
            e = q.pop_front();
            chk("sb_kind_start", 32'(e.is_done), 32'd0);
            chk("sb_addr", dma_rx_address, e.addr);
            chk("sb_code", loading_state, e.code);
          end
        end
        if (done) begin
          if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
          else begin
            e = q.pop_front();
            chk("sb_kind_done", 32'(e.is_done), 32'd1);
          end
        end
      end
    end
  end

  // DMA responder: dma_done a fixed number of cycles after each request,
  // optionally together with dma_error on a chosen transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (resetn && auto_dma && dma_rx_start) begin
        xfer_n++;
        repeat (4) @(negedge clk);
        if (xfer_n == err_on) dma_error = 1'b1;
        dma_done = 1'b1;
        @(negedge clk);
        dma_done  = 1'b0;
        dma_error = 1'b0;
      end
    end
  end

  // Drives start for one cycle; returns at the first negedge after it was sampled.
  task automatic issue_start(input logic [3:0] mask, input logic [31:0] base);
    @(negedge clk);
    operand_mask = mask;
    base_addr    = base;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    int s0;
    bit stable;
    bit seen;
    int cyc;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_loading_state", loading_state, 32'h0);
    chk("rst_addr", dma_rx_address, 32'h0);
    chk("rst_dma_rx_start", 32'(dma_rx_start), 32'd0);
    chk("rst_busy_done_error", {29'd0, busy, done, error}, 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    resetn = 1'b1;

    // All four operands
    s0 = n_starts;
    push_x(32'h1000, 32'h09); push_x(32'h1080, 32'h0A);
    push_x(32'h1100, 32'h0B); push_x(32'h1180, 32'h0C); push_done();
    issue_start(4'b1111, 32'h1000);
    chk("m1111_busy_sel", 32'(busy), 32'd1);
    chk("m1111_code_sel", loading_state, 32'h09);
    @(negedge clk);
    chk("m1111_no_start_t2", 32'(dma_rx_start), 32'd0);
    @(negedge clk);
    chk("m1111_start_t3", 32'(dma_rx_start), 32'd1);
    wait_done("m1111_done");
    chk("m1111_busy_after", 32'(busy), 32'd0);
    chk("m1111_nstarts", 32'(n_starts - s0), 32'd4);
    @(negedge clk);
    chk("m1111_code_idle", loading_state, 32'h0);

    // Sparse mask
    s0 = n_starts;
    push_x(32'h1080, 32'h0A); push_x(32'h1180, 32'h0C); push_done();
    issue_start(4'b1010, 32'h1000);
    chk("m1010_code_sel", loading_state, 32'h0A);
    wait_done("m1010_done");
    chk("m1010_nstarts", 32'(n_starts - s0), 32'd2);

    // Empty mask: done at t+3, no DMA
    s0 = n_starts;
    push_done();
    issue_start(4'b0000, 32'h3000);
    chk("m0000_busy_t1", 32'(busy), 32'd1);
    chk("m0000_code_t1", loading_state, 32'h0);
    @(negedge clk);
    chk("m0000_done_t2", 32'(done), 32'd0);
    @(negedge clk);
    chk("m0000_done_t3", 32'(done), 32'd1);
    repeat (3) @(negedge clk);
    chk("m0000_nstarts", 32'(n_starts - s0), 32'd0);

    // Error together with done on the second transfer
    s0 = n_starts;
    xfer_n = 0;
    err_on = 2;
    push_x(32'h1000, 32'h09); push_x(32'h1080, 32'h0A);
    issue_start(4'b1111, 32'h1000);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (error) seen = 1'b1;
    end
    chk("err_seen", 32'(seen), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_done", 32'(done), 32'd0);
    repeat (10) @(negedge clk);
    chk("err_sticky", 32'(error), 32'd1);
    chk("err_nstarts", 32'(n_starts - s0), 32'd2);
    chk("err_code", loading_state, 32'h0);
    err_on = 0;
    push_x(32'h4000, 32'h09); push_done();
    issue_start(4'b0001, 32'h4000);
    chk("err_cleared", 32'(error), 32'd0);
    wait_done("err_restart_done");

    // dma_idle low for 10 cycles in REQ
    dma_idle = 1'b0;
    push_x(32'h2100, 32'h0B); push_done();
    issue_start(4'b0100, 32'h2000);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (dma_rx_start !== 1'b0 || loading_state !== 32'h0B || dma_rx_address !== 32'h2100)
        stable = 1'b0;
    end
    chk("stall_stable", 32'(stable), 32'd1);
    dma_idle = 1'b1;
    @(negedge clk);
    chk("stall_start_after_idle", 32'(dma_rx_start), 32'd1);
    chk("stall_code_at_start", loading_state, 32'h0B);
    wait_done("stall_done");

`ifdef LOAD_TIMEOUT_EN
    // Watchdog: no dma_done, timeout visible 20 cycles into WAIT
    auto_dma = 1'b0;
    push_x(32'h5000, 32'h09);
    issue_start(4'b0001, 32'h5000);
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (timeout) seen = 1'b1;
    end
    chk("to_seen", 32'(seen), 32'd1);
    chk("to_cycle", 32'(cyc), 32'd23);
    chk("to_error", 32'(error), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
`else
    cyc = 0;
`endif

    // Reset in the middle of WAIT, then a late dma_done
    auto_dma = 1'b0;
    push_x(32'h6080, 32'h0A);
    issue_start(4'b0010, 32'h6000);
    repeat (5) @(negedge clk);
    chk("rmid_in_wait", {busy, loading_state[30:0]}, {1'b1, 31'h0A});
    #2 resetn = 1'b0;
    #1;
    chk("rmid_code", loading_state, 32'h0);
    chk("rmid_addr", dma_rx_address, 32'h0);
    chk("rmid_flags", {27'd0, dma_rx_start, busy, done, error, timeout}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    dma_done = 1'b1;
    @(negedge clk);
    dma_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rmid_late_done_busy", 32'(busy), 32'd0);
    chk("rmid_late_done_code", loading_state, 32'h0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/operand_load_sequencer.md
# operand_load_sequencer

Sequences the four 1024-bit operand loads (N, e, R_N, R2_N) from external memory into the operand register bank via the DMA receive channel. On a start command it issues one DMA read per enabled operand, drives the operand-select `loading_state` code so the register bank captures `dma_rx_data` on `dma_done`, and reports completion or error to the top-level control FSM.

## Interface
- `OPERAND_BYTES`, default 128: address stride between consecutive operands (1024 bits).
- `TIMEOUT_CYCLES`, default 65535: watchdog limit per DMA transfer; used only with `LOAD_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle command pulse; sampled only in IDLE.
- `base_addr` in 32: byte address of N; operand k sits at `base_addr + k*OPERAND_BYTES`, with k=0..3 for N, e, R_N, R2_N.
- `operand_mask` in 4: bit k=1 loads operand k; captured on accepted `start`.
- `loading_state` out 32: operand-select code for the register bank.
- `dma_rx_address` out 32: read address for the current transfer.
- `dma_rx_start` out 1: one-cycle DMA request pulse.
- `dma_done`, `dma_idle`, `dma_error` in 1 each: DMA status.
- `busy` out 1: high from accepted `start` until DONE/ERROR.
- `done` out 1: one-cycle pulse when all enabled operands are loaded.
- `error` out 1: sticky; cleared by the next accepted `start`.
- `timeout` out 1: sticky watchdog flag. Present only with `LOAD_TIMEOUT_EN`.

## Operation
- Operand codes: N=0x09, e=0x0A, R_N=0x0B, R2_N=0x0C. Outside SEL, REQ and WAIT, `loading_state` is 0x00.
- States: IDLE, SEL, REQ, WAIT, DONE, ERROR.
- IDLE: on `start`, capture `base_addr` and `operand_mask`, clear `error` and `timeout`, set k=0, go to SEL.
- SEL: scan for the lowest k≥current with its mask bit set.
  - If found, set `loading_state`=code(k) and `dma_rx_address`=base+k*OPERAND_BYTES, then go to REQ.
  - If none remain, go to DONE.
  - Mask 0000 therefore goes IDLE→SEL→DONE with no DMA activity.
- REQ: wait for `dma_idle`=1. Assert `dma_rx_start` for exactly one cycle, then go to WAIT.
- WAIT: hold `loading_state` and `dma_rx_address` stable.
  - On `dma_done`, set k=k+1 and go to SEL. If k was 3, go to DONE.
  - `dma_done` in any state other than WAIT is ignored.
- DONE: pulse `done` for one cycle and return to IDLE.
- ERROR: set `error`, drop `busy`, return to IDLE next cycle.
- `dma_error` in REQ or WAIT forces ERROR.
  - If `dma_error` and `dma_done` are asserted in the same cycle, error wins and k does not advance.
- Address arithmetic: 32-bit modulo 2^32; wrap-around is not flagged.
- `start` while busy is ignored. It is not queued.

## Timing
- Reset values: `loading_state`=0, `dma_rx_address`=0, `dma_rx_start`=0, `busy`=0, `done`=0, `error`=0, `timeout`=0; state=IDLE.
- All outputs are registered.
- `start` at cycle t gives SEL at t+1 and, if `dma_idle` is already 1, `dma_rx_start` at t+3.
- `loading_state` is valid from SEL onward, so it is stable at least 2 cycles before `dma_rx_start` and through the `dma_done` cycle.
- Per operand overhead: 3 cycles (SEL, REQ, WAIT exit) plus DMA latency.
- `done` is asserted the cycle after DONE is entered.
- Reset mid-transfer returns to IDLE immediately. Any DMA completion that arrives afterwards is ignored.

## Configuration
- `LOAD_TIMEOUT_EN` defined:
  - A 32-bit counter clears on REQ exit and counts in WAIT.
  - When it reaches `TIMEOUT_CYCLES`, set `timeout` and `error` and go to ERROR.
- `LOAD_TIMEOUT_EN` undefined: there is no counter and no `timeout` port. WAIT waits indefinitely.

## Structure
- Shared package `rsa_pkg`:
  - Operand code localparams `LOAD_N`, `LOAD_E`, `LOAD_RN`, `LOAD_R2N`, `LOAD_NONE`.
  - The state enum encoding.
  - `OPERAND_BYTES`.
- No sub-module is needed. The next-operand priority scan is a function local to the module.

## Test plan
- Mask 1111, base 0x1000, DMA done 5 cycles after each start → addresses 0x1000, 0x1080, 0x1100, 0x1180; codes 09, 0A, 0B, 0C; one `done`.
- Mask 1010 → only 0x1080/0A and 0x1180/0C are issued; exactly 2 `dma_rx_start` pulses.
- Mask 0000 → `done` at t+3, no `dma_rx_start`.
- `dma_error` together with `dma_done` on the second transfer → `error`=1, `busy`=0, no third request. A following `start` clears `error`.
- `dma_idle`=0 for 10 cycles in REQ → `dma_rx_start` is delayed until the cycle `dma_idle` rises; `loading_state` stays stable throughout.
- With `LOAD_TIMEOUT_EN` and TIMEOUT_CYCLES=20, `dma_done` never arrives → `timeout` and `error` set 20 cycles into WAIT. Separately, reset asserted mid-WAIT → all outputs return to their reset values asynchronously.
